// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: four requesters share one fifo write port,
// each grant lasting up to BURST words, with stall on fifo_full.
module fifo_wr_arbiter #(
    parameter int d_w   = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [4*d_w-1:0] req_data,
    output logic [3:0]       gnt,
    output logic [3:0]       ack,
    input  logic             fifo_full,
    output logic             fifo_write,
    output logic [d_w-1:0]   fifo_data_in
);

    localparam int CW = $clog2(BURST) + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_r, state_nx_s;
    logic [3:0]      gnt_r, gnt_nx_s;
    logic [1:0]      gidx_r, gidx_nx_s;
    logic [1:0]      rr_ptr_r, rr_ptr_nx_s;
    logic [CW-1:0]   cnt_r, cnt_nx_s;
    logic [1:0]      pick_idx_s;
    logic            pick_vld_s;
    logic            write_s;
    logic            last_s;

    // Round-robin pick: scan downward so the requester closest to rr_ptr wins.
    always_comb begin
        pick_idx_s = rr_ptr_r;
        pick_vld_s = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (req[rr_ptr_r + 2'(i)]) begin
                pick_idx_s = rr_ptr_r + 2'(i);
                pick_vld_s = 1'b1;
            end else begin
                pick_vld_s = pick_vld_s;
            end
        end
    end

    // Write strobe; reset overrides every other input.
    always_comb begin
        write_s = (state_r == GRANT) && req[gidx_r] && !fifo_full && !rst;
        last_s  = (cnt_r == CW'(BURST - 1));
    end

    // Next-state logic; a release always advances the pointer past the owner.
    always_comb begin
        state_nx_s  = state_r;
        gnt_nx_s    = gnt_r;
        gidx_nx_s   = gidx_r;
        rr_ptr_nx_s = rr_ptr_r;
        cnt_nx_s    = cnt_r;
        case (state_r)
            IDLE: begin
                if (pick_vld_s) begin
                    state_nx_s = GRANT;
                    gidx_nx_s  = pick_idx_s;
                    gnt_nx_s   = 4'b0001 << pick_idx_s;
                    cnt_nx_s   = '0;
                end else begin
                    gnt_nx_s   = 4'b0000;
                end
            end
            GRANT: begin
                if (!req[gidx_r]) begin
                    state_nx_s  = IDLE;
                    gnt_nx_s    = 4'b0000;
                    rr_ptr_nx_s = gidx_r + 2'd1;
                end else if (fifo_full) begin
                    state_nx_s  = GRANT;
                end else begin
                    cnt_nx_s = cnt_r + CW'(1);
                    if (last_s) begin
                        state_nx_s  = IDLE;
                        gnt_nx_s    = 4'b0000;
                        rr_ptr_nx_s = gidx_r + 2'd1;
                    end else begin
                        state_nx_s  = GRANT;
                    end
                end
            end
            default: begin
                state_nx_s = IDLE;
                gnt_nx_s   = 4'b0000;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            gnt_r    <= 4'b0000;
            gidx_r   <= 2'd0;
            rr_ptr_r <= 2'd0;
            cnt_r    <= '0;
        end else begin
            state_r  <= state_nx_s;
            gnt_r    <= gnt_nx_s;
            gidx_r   <= gidx_nx_s;
            rr_ptr_r <= rr_ptr_nx_s;
            cnt_r    <= cnt_nx_s;
        end
    end

    // Output mapping.
    always_comb begin
        gnt        = gnt_r;
        fifo_write = write_s;
        ack        = write_s ? gnt_r : 4'b0000;
        if (state_r == GRANT) begin
            fifo_data_in = req_data[gidx_r*d_w +: d_w];
        end else begin
            fifo_data_in = '0;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (d_w=8, BURST=4) with per-cycle checks.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        fifo_full;
    logic        fifo_write;
    logic [7:0]  fifo_data_in;

    int n_vec = 0;
    int n_err = 0;
    int n_wr_exp = 0;
    int n_wr_dut = 0;
    int n_ack_dut = 0;
    int n_wr_full = 0;
    logic [7:0] dat [4];

    fifo_wr_arbiter #(.d_w(8), .BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt), .ack(ack), .fifo_full(fifo_full),
        .fifo_write(fifo_write), .fifo_data_in(fifo_data_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string step, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s/%s: observed %0h expected %0h", step, tag, obs, exp);
        end
    endtask

    function automatic int oh2idx(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh[i]) return i;
        return 0;
    endfunction

    // One clock cycle: drive after negedge, check settled outputs before posedge.
    task automatic step(input string name, input logic r, input logic [3:0] rq, input logic f,
                        input logic [3:0] eg, input logic ew);
        logic [3:0] ea;
        logic [7:0] ed;
        @(negedge clk);
        rst = r; req = rq; fifo_full = f;
        req_data = {dat[3], dat[2], dat[1], dat[0]};
        #1;
        ea = ew ? eg : 4'b0000;
        ed = (eg != 4'b0000) ? dat[oh2idx(eg)] : 8'h00;
        chk(name, "gnt", 32'(gnt), 32'(eg));
        chk(name, "fifo_write", 32'(fifo_write), 32'(ew));
        chk(name, "ack", 32'(ack), 32'(ea));
        chk(name, "fifo_data_in", 32'(fifo_data_in), 32'(ed));
        if (fifo_write === 1'b1) n_wr_dut++;
        if (fifo_write === 1'b1 && fifo_full === 1'b1) n_wr_full++;
        n_ack_dut += $countones(ack);
        if (ew) begin
            n_wr_exp++;
            dat[oh2idx(eg)] = dat[oh2idx(eg)] + 8'd1;
        end
    endtask

    initial begin
        dat[0] = 8'h01; dat[1] = 8'h41; dat[2] = 8'h81; dat[3] = 8'hC1;
        rst = 1'b1; req = 4'b0000; fifo_full = 1'b0; req_data = 32'h0;
        repeat (2) @(posedge clk);

        // reset holds outputs low even with requests present
        step("rst_hold", 1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0);

        // single requester: 1-cycle latency, 4-word burst, one idle gap, re-grant
        step("single_idle", 1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0);
        for (int j = 0; j < 4; j++) step("single_burst", 1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1);
        step("single_gap", 1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0);
        step("single_regrant", 1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1);
        step("single_drop", 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0);
        step("idle_noreq", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        // round robin from a fresh pointer
        step("rr_reset", 1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step("rr_idle", 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0);
            for (int j = 0; j < 4; j++) step("rr_burst", 1'b0, 4'b1111, 1'b0, 4'b0001 << k, 1'b1);
        end
        step("rr_wrap_idle", 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0);
        step("rr_wrap_0", 1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1);
        step("rr_drop", 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0);
        step("rr_after", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        // full stall on requester 2, other requesters toggling meanwhile
        step("stall_idle", 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0);
        step("stall_w1", 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1);
        step("stall_w2", 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1);
        step("stall_f1", 1'b0, 4'b1110, 1'b1, 4'b0100, 1'b0);
        step("stall_f2", 1'b0, 4'b0110, 1'b1, 4'b0100, 1'b0);
        step("stall_f3", 1'b0, 4'b1100, 1'b1, 4'b0100, 1'b0);
        step("stall_w3", 1'b0, 4'b1110, 1'b0, 4'b0100, 1'b1);
        step("stall_w4", 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1);
        step("stall_end", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        // early release by requester 1; pointer moves to 2
        step("early_idle", 1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0);
        step("early_w1", 1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1);
        step("early_w2", 1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1);
        step("early_drop", 1'b0, 4'b1100, 1'b0, 4'b0010, 1'b0);
        step("early_arb", 1'b0, 4'b1100, 1'b0, 4'b0000, 1'b0);
        step("early_g2", 1'b0, 4'b1100, 1'b0, 4'b0100, 1'b1);

        // reset mid-burst: no write during reset, pointer back to 0
        step("mid_rst", 1'b1, 4'b1111, 1'b0, 4'b0100, 1'b0);
        step("post_rst_idle", 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0);
        step("post_rst_g0", 1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1);
        step("post_rst_drop", 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0);
        step("final_idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        // scoreboard totals
        chk("score", "write_count", 32'(n_wr_dut), 32'(n_wr_exp));
        chk("score", "ack_count", 32'(n_ack_dut), 32'(n_wr_exp));
        chk("score", "write_while_full", 32'(n_wr_full), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter: d_w, default 8, data word width in bits; matches the fifo data width.
REQ-002 Parameter: BURST, default 4, maximum words written per grant; legal range 1..16.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: req  input  4  per-requester write request; bit k belongs to requester k.
REQ-006 Port: req_data  input  4*d_w  requester k data on bits [k*d_w +: d_w]; must be valid whenever req[k]=1.
REQ-007 Port: gnt  output  4  registered one-hot grant (all-zero when idle).
REQ-008 Port: ack  output  4  one-hot; ack[k]=1 means requester k's word is written at this posedge.
REQ-009 Port: fifo_full  input  1  full flag from the fifo.
REQ-010 Port: fifo_write  output  1  fifo write enable.
REQ-011 Port: fifo_data_in  output  d_w  fifo write data.

Function
REQ-012 The block SHALL have two states: IDLE and GRANT.
REQ-013 In IDLE with req!=0, the block SHALL pick the first requester with req set, scanning from rr_ptr upward mod 4, load gnt one-hot, clear burst counter cnt, and enter GRANT next cycle.
REQ-014 In IDLE with req=0, the block SHALL stay in IDLE with gnt=0.
REQ-015 Request-to-grant latency SHALL be exactly 1 cycle; no write occurs in the IDLE cycle.
REQ-016 In GRANT with granted index g, fifo_write SHALL be combinational: req[g] & ~fifo_full.
REQ-017 ack SHALL equal gnt when fifo_write=1, else 0; ack is never asserted outside GRANT.
REQ-018 fifo_data_in SHALL be req_data of the granted requester while in GRANT, and 0 in IDLE.
REQ-019 Each write SHALL increment cnt (width ceil(log2(BURST))+1, no wrap possible).
REQ-020 GRANT SHALL exit to IDLE at the edge completing the BURST-th write of the grant.
REQ-021 GRANT SHALL exit to IDLE at any edge where req[g]=0 (no write that cycle).
REQ-022 GRANT with req[g]=1 and fifo_full=1 SHALL stall: no write, no ack, cnt held, state held.
REQ-023 On every GRANT->IDLE transition, rr_ptr SHALL become (g+1) mod 4 and gnt SHALL clear.
REQ-024 Requests from non-granted requesters SHALL be ignored until the next IDLE arbitration.
REQ-025 A requester deasserting and reasserting req SHALL re-enter arbitration with no priority kept.
REQ-026 Changes on req bits other than req[g] during GRANT SHALL not affect fifo_write, ack, or state.
REQ-027 Minimum gap between consecutive grants SHALL be one IDLE cycle.

Reset
REQ-028 With rst=1 at a posedge, next cycle: state=IDLE, gnt=0, cnt=0, rr_ptr=0, fifo_write=0, ack=0, fifo_data_in=0.
REQ-029 Reset asserted mid-GRANT SHALL abort the burst with no further write; rst overrides all other inputs.
REQ-030 While rst=1, fifo_write and ack SHALL be 0 even if req and fifo_full=0 are present.

Verification
REQ-031 Single requester: req=4'b0001, req_data[7:0]=1,2,3,... every write, full=0, BURST=4 -> gnt=0001 1 cycle after req; words 1..4 written in 4 consecutive cycles; 1 IDLE cycle; new grant to requester 0; words 5.. follow.
REQ-032 Round-robin: req=4'b1111 held -> grant order 0,1,2,3,0; each grant gives exactly 4 writes with matching ack bits.
REQ-033 Full stall: requester 2 granted; fifo_full=1 for 3 cycles after its 2nd write -> fifo_write=0 and ack=0 for those 3 cycles; writes 3 and 4 follow once full drops; total 4 writes, no duplicate or lost word.
REQ-034 Early release: requester 1 drops req after 2 writes -> state returns to IDLE; rr_ptr=2; a pending req[3] and req[2] yield grant to requester 2 next.
REQ-035 Reset mid-burst: rst=1 for 1 cycle after the 1st write of a grant -> no write in the following cycle; gnt=0; next arbitration with req=1111 grants requester 0.
REQ-036 Scoreboard: fifo_write pulses equal total ack pulses; fifo_data_in sequence equals per-requester accepted req_data order; fifo_write never 1 while fifo_full=1.
